// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead adder/subtractor.
// Holds the control state encoding and the helpers that derive the segment
// count and the segment-index width from the WIDTH/SEG parameters.
package cla_seq_adder_pkg;

  // Default operand width and segment width.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  // Control states: waiting for start, computing segments, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of segments (cycles in RUN) for an operation.
  function automatic int calc_nseg(input int width, input int seg);
    return width / seg;
  endfunction

  // Width of the segment index; at least one bit even for a single segment.
  function automatic int calc_idx_w(input int nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

  // Width of a bit position inside a WIDTH-bit word, at least one bit.
  function automatic int calc_pos_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Operation bus of the sequential adder.
//   master: drives start/sub/cin/x/y, observes busy/done/s/cout/ovf.
//   slave : the adder itself.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, x, y,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, cin, x, y,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/cla_seq_adder_segment.sv
// cla_segment: one SEG-bit carry-lookahead block, purely combinational.
//   x, y  : segment operand bits
//   c     : carry into the segment
//   s     : segment sum bits
//   g, p  : segment group generate / propagate
//   cout  : carry out of the segment
//   c_msb : carry into the top bit of the segment (for signed overflow)
module cla_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           c,
  output logic [SEG-1:0] s,
  output logic           g,
  output logic           p,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG-1:0] gen_s;
  logic [SEG-1:0] prop_s;
  logic [SEG:0]   carry_s;
  logic           look_s;
  logic           term_s;
  logic           grp_g_s;
  logic           grp_t_s;

  assign gen_s  = x & y;
  assign prop_s = x ^ y;

  // Expanded lookahead carries: c[i+1] = OR_j(g[j] & p[j+1..i]) | p[0..i] & c.
  always_comb begin
    carry_s    = '0;
    look_s     = 1'b0;
    term_s     = 1'b0;
    carry_s[0] = c;
    for (int i = 0; i < SEG; i++) begin
      look_s = c;
      for (int j = 0; j <= i; j++) begin
        look_s = look_s & prop_s[j];
      end
      for (int j = 0; j <= i; j++) begin
        term_s = gen_s[j];
        for (int k = j + 1; k <= i; k++) begin
          term_s = term_s & prop_s[k];
        end
        look_s = look_s | term_s;
      end
      carry_s[i+1] = look_s;
    end
  end

  // Group generate: carry out of the segment assuming a zero carry in.
  always_comb begin
    grp_g_s = 1'b0;
    grp_t_s = 1'b0;
    for (int j = 0; j < SEG; j++) begin
      grp_t_s = gen_s[j];
      for (int k = j + 1; k < SEG; k++) begin
        grp_t_s = grp_t_s & prop_s[k];
      end
      grp_g_s = grp_g_s | grp_t_s;
    end
  end

  assign s     = prop_s ^ carry_s[SEG-1:0];
  assign g     = grp_g_s;
  assign p     = &prop_s;
  assign cout  = carry_s[SEG];
  assign c_msb = carry_s[SEG-1];

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle carry-lookahead adder/subtractor.
// Processes WIDTH bits SEG at a time, LSB segment first, with the carry
// registered between segments. One lookahead block is shared across all
// segments and fed through a mux driven by the segment index.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : start/sub/cin/x/y in, busy/done/s/cout/ovf out
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic           clk,
  input  logic           rst,
  cla_seq_adder_if.slave bus
);

  localparam int NSEG  = calc_nseg(WIDTH, SEG);
  localparam int IDX_W = calc_idx_w(NSEG);
  localparam int POS_W = calc_pos_w(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSEG - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic             accept_s;
  logic             last_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] s_next_s;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [POS_W-1:0] base_s;
  logic [SEG-1:0]   seg_x_s;
  logic [SEG-1:0]   seg_y_s;
  logic [SEG-1:0]   seg_sum_s;
  logic             seg_g_s;
  logic             seg_p_s;
  logic             seg_cout_s;
  logic             seg_msb_s;

  // Next-state logic; start is only honoured while idle.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == IDX_LAST) begin
          state_next_s = DONE;
          last_s       = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Select the active segment of the latched operands and merge its sum.
  always_comb begin
    base_s   = POS_W'(int'(idx_r) * SEG);
    seg_x_s  = x_r[base_s +: SEG];
    seg_y_s  = y_r[base_s +: SEG];
    s_next_s = s_r;
    s_next_s[base_s +: SEG] = seg_sum_s;
  end

  cla_segment #(
    .SEG (SEG)
  ) u_seg (
    .x     (seg_x_s),
    .y     (seg_y_s),
    .c     (carry_r),
    .s     (seg_sum_s),
    .g     (seg_g_s),
    .p     (seg_p_s),
    .cout  (seg_cout_s),
    .c_msb (seg_msb_s)
  );

  // State, handshake flags, operand/carry registers and the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // Subtract is x + ~y + 1; cin has no effect in that mode.
            x_r     <= bus.x;
            y_r     <= bus.y ^ {WIDTH{bus.sub}};
            carry_r <= bus.sub | bus.cin;
            idx_r   <= '0;
            s_r     <= '0;
          end
        end
        RUN: begin
          s_r     <= s_next_s;
          carry_r <= seg_g_s | (seg_p_s & carry_r);
          if (last_s) begin
            idx_r  <= '0;
            cout_r <= seg_cout_s;
            ovf_r  <= seg_msb_s ^ seg_cout_s;
          end else begin
            idx_r  <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: table of 16-bit vectors plus sequences
// for start-while-busy, async reset mid-operation, held start and the
// single-segment / single-bit-segment parameter variants.
module tb_cla_seq_adder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cla_seq_adder_if #(.WIDTH(16)) if16 ();
  cla_seq_adder_if #(.WIDTH(8))  if8a ();
  cla_seq_adder_if #(.WIDTH(8))  if8b ();

  cla_seq_adder #(.WIDTH(16), .SEG(4)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  cla_seq_adder #(.WIDTH(8),  .SEG(8)) dut8a (.clk(clk), .rst(rst), .bus(if8a.slave));
  cla_seq_adder #(.WIDTH(8),  .SEG(1)) dut8b (.clk(clk), .rst(rst), .bus(if8b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One 16-bit operation; lat counts cycles from the start-sampling edge to
  // the cycle where done is high (inclusive), -1 if done never appears.
  task automatic run_op(input logic sb, input logic ci, input logic [15:0] a,
                        input logic [15:0] b, output int lat, output int bn,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output logic dn);
    bit seen;
    @(negedge clk);
    if16.sub = sb; if16.cin = ci; if16.x = a; if16.y = b; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    lat = -1; bn = 0; seen = 1'b0; rs = '0; rc = 1'b0; ro = 1'b0; dn = 1'b1;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (if16.busy) bn++;
      if (if16.done) begin
        seen = 1'b1;
        lat  = n + 1;
        rs = if16.s; rc = if16.cout; ro = if16.ovf;
        @(posedge clk); #1;
        dn = if16.done;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Wait (bounded) for done on the 16-bit instance; returns 1 if seen.
  task automatic wait_done16(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (if16.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  int          lat;
  int          bn;
  logic [15:0] rs;
  logic        rc;
  logic        ro;
  logic        dn;
  bit          seen;
  int          lat_a;
  int          lat_b;

  initial begin
    checks = 0; failures = 0;
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'h00FF, 16'h0F00, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1;
    if16.start = 1'b0; if16.sub = 1'b0; if16.cin = 1'b0; if16.x = '0; if16.y = '0;
    if8a.start = 1'b0; if8a.sub = 1'b0; if8a.cin = 1'b0; if8a.x = '0; if8a.y = '0;
    if8b.start = 1'b0; if8b.sub = 1'b0; if8b.cin = 1'b0; if8b.x = '0; if8b.y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s",    32'(if16.s),    32'h0);
    check("rst_busy", 32'(if16.busy), 32'h0);
    check("rst_done", 32'(if16.done), 32'h0);
    check("rst_cout", 32'(if16.cout), 32'h0);
    check("rst_ovf",  32'(if16.ovf),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sub, vecs[i].cin, vecs[i].x, vecs[i].y, lat, bn, rs, rc, ro, dn);
      check($sformatf("vec%0d_lat", i),   32'(lat), 32'd5);
      check($sformatf("vec%0d_busy", i),  32'(bn),  32'd4);
      check($sformatf("vec%0d_s", i),     32'(rs),  32'(vecs[i].s));
      check($sformatf("vec%0d_cout", i),  32'(rc),  32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i),   32'(ro),  32'(vecs[i].ovf));
      check($sformatf("vec%0d_pulse", i), 32'(dn),  32'h0);
    end

    // start during RUN must not re-latch operands
    @(negedge clk);
    if16.sub = 1'b0; if16.cin = 1'b0; if16.x = 16'h1111; if16.y = 16'h2222; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    @(posedge clk); #1;
    if16.start = 1'b1; if16.x = 16'hAAAA; if16.y = 16'h5555; if16.sub = 1'b1;
    wait_done16(seen);
    if16.start = 1'b0;
    check("ign_seen", 32'(seen),      32'h1);
    check("ign_s",    32'(if16.s),    32'h3333);
    check("ign_cout", 32'(if16.cout), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("ign_idle_busy", 32'(if16.busy), 32'h0);
    check("ign_idle_s",    32'(if16.s),    32'h3333);

    // async reset in the middle of an operation
    @(negedge clk);
    if16.sub = 1'b0; if16.x = 16'h1234; if16.y = 16'h1111; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(if16.busy), 32'h0);
    check("arst_done", 32'(if16.done), 32'h0);
    check("arst_s",    32'(if16.s),    32'h0);
    @(posedge clk); #1;
    check("arst_hold_busy", 32'(if16.busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 1'b0, 16'h0003, 16'h0004, lat, bn, rs, rc, ro, dn);
    check("post_rst_s",   32'(rs),  32'h0007);
    check("post_rst_lat", 32'(lat), 32'd5);

    // start held high: back-to-back operations with one idle cycle between
    @(negedge clk);
    if16.sub = 1'b0; if16.cin = 1'b0; if16.x = 16'h0001; if16.y = 16'h0002; if16.start = 1'b1;
    @(posedge clk); #1;
    wait_done16(seen);
    check("b2b_seen1", 32'(seen),   32'h1);
    check("b2b_s1",    32'(if16.s), 32'h0003);
    if16.x = 16'h0010; if16.y = 16'h0020;
    @(posedge clk); #1;
    check("b2b_idle_busy", 32'(if16.busy), 32'h0);
    check("b2b_idle_done", 32'(if16.done), 32'h0);
    @(posedge clk); #1;
    if16.start = 1'b0;
    check("b2b_rerun_busy", 32'(if16.busy), 32'h1);
    wait_done16(seen);
    check("b2b_seen2", 32'(seen),   32'h1);
    check("b2b_s2",    32'(if16.s), 32'h0030);

    // 8-bit variants: one full-width segment and eight 1-bit segments
    @(negedge clk);
    if8a.x = 8'hC8; if8a.y = 8'h64; if8a.start = 1'b1;
    if8b.x = 8'hC8; if8b.y = 8'h64; if8b.start = 1'b1;
    @(posedge clk); #1;
    if8a.start = 1'b0; if8b.start = 1'b0;
    lat_a = -1; lat_b = -1;
    for (int n = 0; n < 30; n++) begin
      if (if8a.done && lat_a < 0) lat_a = n + 1;
      if (if8b.done && lat_b < 0) lat_b = n + 1;
      @(posedge clk); #1;
    end
    check("w8s8_lat",  32'(lat_a),     32'd2);
    check("w8s8_s",    32'(if8a.s),    32'h2C);
    check("w8s8_cout", 32'(if8a.cout), 32'h1);
    check("w8s8_ovf",  32'(if8a.ovf),  32'h0);
    check("w8s1_lat",  32'(lat_b),     32'd9);
    check("w8s1_s",    32'(if8b.s),    32'h2C);
    check("w8s1_cout", 32'(if8b.cout), 32'h1);
    check("w8s1_ovf",  32'(if8b.ovf),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
